// File: rtl/icache_pf.sv
// Blocking instruction cache with a one-line next-line prefetch buffer and
// address-targeted invalidation; all storage is flops, lookups are combinational.
module icache_pf #(
   parameter int WAYS       = 4,
   parameter int SETS       = 16,
   parameter int LINE_BYTES = 32,
   parameter int PF_ENABLE  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             ufp_addr,
   input  logic [3:0]              ufp_rmask,
   output logic [31:0]             ufp_rdata,
   output logic                    ufp_resp,
   output logic [31:0]             dfp_addr,
   output logic                    dfp_read,
   input  logic [8*LINE_BYTES-1:0] dfp_rdata,
   input  logic                    dfp_resp,
   input  logic                    inv_req,
   input  logic [31:0]             inv_addr,
   output logic                    inv_resp
);

   localparam int LB   = $clog2(LINE_BYTES);
   localparam int SB   = $clog2(SETS);
   localparam int TW   = 32 - LB - SB;
   localparam int LW   = 32 - LB;
   localparam int LWAY = $clog2(WAYS);
   localparam int DW   = 8 * LINE_BYTES;

   typedef enum logic [2:0] {READY, COMPARE, FILL, PREFETCH, INVAL} state_t;

   state_t                              state;
   logic [SETS-1:0][WAYS-1:0]           valid;
   logic [SETS-1:0][WAYS-1:0][TW-1:0]   tags;
   logic [DW-1:0]                       data [SETS][WAYS];
   logic [SETS-1:0][WAYS-2:0]           plru;
   logic [31:0]                         req_addr, inv_addr_q;
   logic                                pb_valid;
   logic [LW-1:0]                       pb_line;
   logic [DW-1:0]                       pb_data;
   logic                                pf_armed, pf_wrap;
   logic [LW-1:0]                       pf_line;

   // Tree-PLRU: bit 0 steers left, 1 steers right; heap-ordered nodes.
   function automatic logic [LWAY-1:0] plru_victim(input logic [WAYS-2:0] b);
      int node;
      int w;
      node = 0;
      for (int l = 0; l < LWAY; l++) node = 2 * node + 1 + int'(b[node]);
      w = node - (WAYS - 1);
      return w[LWAY-1:0];
   endfunction

   function automatic logic [WAYS-2:0] plru_upd(input logic [WAYS-2:0] b,
                                                input logic [LWAY-1:0] w);
      logic [WAYS-2:0] r;
      logic            d;
      int              node;
      r    = b;
      node = 0;
      for (int l = 0; l < LWAY; l++) begin
         d       = w[LWAY-1-l];
         r[node] = ~d;
         node    = 2 * node + 1 + int'(d);
      end
      return r;
   endfunction

   // One lookup port shared by demand, prefetch-target and invalidate checks.
   logic [31:0]     lk_addr;
   logic [SB-1:0]   lk_set;
   logic [TW-1:0]   lk_tag;
   logic [LW-1:0]   lk_line;
   logic [LB-3:0]   wsel;
   logic [WAYS-1:0] hit_vec, free_vec;
   logic [LWAY-1:0] hit_way, victim;
   logic            hit, pb_hit, wr_en, take_ufp, accept_en;
   state_t          accept_next;
   logic            unused_bits;

   always_comb begin
      lk_addr = req_addr;
      if (state == PREFETCH)   lk_addr = {pf_line, {LB{1'b0}}};
      else if (state == INVAL) lk_addr = inv_addr_q;
   end

   assign lk_set      = lk_addr[LB+SB-1:LB];
   assign lk_tag      = lk_addr[31:LB+SB];
   assign lk_line     = lk_addr[31:LB];
   assign wsel        = lk_addr[LB-1:2];
   assign unused_bits = ^lk_addr[1:0];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign hit_vec[w]  = valid[lk_set][w] && (tags[lk_set][w] == lk_tag);
      assign free_vec[w] = ~valid[lk_set][w];
   end

   always_comb begin
      hit_way = '0;
      victim  = plru_victim(plru[lk_set]);
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w])  hit_way = LWAY'(w);
         if (free_vec[w]) victim  = LWAY'(w);
      end
   end

   assign hit      = |hit_vec;
   assign pb_hit   = pb_valid && (pb_line == lk_line);
   assign ufp_resp = (state == COMPARE) && (hit || pb_hit);
   assign inv_resp = (state == INVAL);
   assign wr_en    = ((state == COMPARE) && !hit && pb_hit) ||
                     ((state == FILL) && dfp_read && dfp_resp);

   always_comb begin
      ufp_rdata = '0;
      if (ufp_resp)
         ufp_rdata = hit ? data[lk_set][hit_way][wsel*32 +: 32] : pb_data[wsel*32 +: 32];
   end

   // Request acceptance shared by READY and a responding COMPARE (streaming hits).
   assign take_ufp  = !inv_req && (|ufp_rmask);
   assign accept_en = (state == READY) || ufp_resp;
   always_comb begin
      accept_next = READY;
      if (inv_req)       accept_next = INVAL;
      else if (take_ufp) accept_next = COMPARE;
      else if (pf_armed) accept_next = PREFETCH;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= READY;
         valid      <= '0;
         plru       <= '0;
         pb_valid   <= 1'b0;
         pb_line    <= '0;
         pf_armed   <= 1'b0;
         pf_wrap    <= 1'b0;
         pf_line    <= '0;
         req_addr   <= '0;
         inv_addr_q <= '0;
         dfp_read   <= 1'b0;
         dfp_addr   <= '0;
      end else begin
         if (accept_en) begin
            state <= accept_next;
            if (take_ufp) req_addr   <= ufp_addr;
            if (inv_req)  inv_addr_q <= inv_addr;
         end
         if (wr_en) begin
            valid[lk_set][victim] <= 1'b1;
            plru[lk_set]          <= plru_upd(plru[lk_set], victim);
            if (PF_ENABLE != 0) begin
               pf_armed <= 1'b1;
               pf_line  <= lk_line + LW'(1);
               pf_wrap  <= &lk_line;
            end
         end
         case (state)
            COMPARE: begin
               if (hit)         plru[lk_set] <= plru_upd(plru[lk_set], hit_way);
               else if (pb_hit) pb_valid     <= 1'b0;
               else             state        <= FILL;
            end
            FILL: begin
               if (dfp_read && dfp_resp) begin
                  dfp_read <= 1'b0;
                  state    <= COMPARE;
               end else begin
                  dfp_read <= 1'b1;
                  dfp_addr <= {lk_line, {LB{1'b0}}};
               end
            end
            PREFETCH: begin
               if (!dfp_read) begin
                  if (pf_wrap || hit) begin
                     pf_armed <= 1'b0;
                     state    <= READY;
                  end else begin
                     dfp_read <= 1'b1;
                     dfp_addr <= {pf_line, {LB{1'b0}}};
                  end
               end else if (dfp_resp) begin
                  dfp_read <= 1'b0;
                  pb_valid <= 1'b1;
                  pb_line  <= pf_line;
                  pf_armed <= 1'b0;
                  state    <= READY;
               end
            end
            INVAL: begin
               if (hit)    valid[lk_set][hit_way] <= 1'b0;
               if (pb_hit) pb_valid <= 1'b0;
               state <= READY;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data[lk_set][victim] <= (state == FILL) ? dfp_rdata : pb_data;
         tags[lk_set][victim] <= lk_tag;
      end
      if ((state == PREFETCH) && dfp_read && dfp_resp) pb_data <= dfp_rdata;
   end

endmodule

// File: tb/tb_icache_pf.sv
// Directed + randomized bench for icache_pf against a resident-line/buffer model.
module tb_icache_pf;
   localparam int          LB   = 5;
   localparam logic [31:0] MAXL = 32'hFFFF_FFFF >> LB;

   logic         clk = 0, rst = 1;
   logic [31:0]  ufp_addr = 0, ufp_rdata, dfp_addr, inv_addr = 0;
   logic [3:0]   ufp_rmask = 0;
   logic         ufp_resp, dfp_read, dfp_resp = 0, inv_req = 0, inv_resp;
   logic [255:0] dfp_rdata = 0;

   logic [31:0]  n_ufp_addr = 0, n_ufp_rdata, n_dfp_addr, n_inv_addr = 0;
   logic [3:0]   n_ufp_rmask = 0;
   logic         n_ufp_resp, n_dfp_read, n_dfp_resp = 0, n_inv_req = 0, n_inv_resp;
   logic [255:0] n_dfp_rdata = 0;

   icache_pf #(.WAYS(4), .SETS(16), .LINE_BYTES(32), .PF_ENABLE(1)) u_dut (
      .clk(clk), .rst(rst), .ufp_addr(ufp_addr), .ufp_rmask(ufp_rmask),
      .ufp_rdata(ufp_rdata), .ufp_resp(ufp_resp), .dfp_addr(dfp_addr),
      .dfp_read(dfp_read), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
      .inv_req(inv_req), .inv_addr(inv_addr), .inv_resp(inv_resp));

   icache_pf #(.WAYS(4), .SETS(16), .LINE_BYTES(32), .PF_ENABLE(0)) u_nopf (
      .clk(clk), .rst(rst), .ufp_addr(n_ufp_addr), .ufp_rmask(n_ufp_rmask),
      .ufp_rdata(n_ufp_rdata), .ufp_resp(n_ufp_resp), .dfp_addr(n_dfp_addr),
      .dfp_read(n_dfp_read), .dfp_rdata(n_dfp_rdata), .dfp_resp(n_dfp_resp),
      .inv_req(n_inv_req), .inv_addr(n_inv_addr), .inv_resp(n_inv_resp));

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h1004) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic logic [255:0] mk_line(input logic [31:0] a);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[w*32 +: 32] = mem_word({a[31:5], 5'b0} + 32'(w * 4));
      return l;
   endfunction

   // Memory responder: fixed latency in dfp_read cycles, logs each line read.
   int           lat = 3, wcnt = 0, last_fill_cyc = 0, n_reads = 0;
   bit           resp_en = 1, late_pulse = 0;
   logic [31:0]  held_addr = 0;
   logic [31:0]  exp_q[$], got_q[$];

   always @(negedge clk) begin
      if (!ufp_resp) chk("rdata_idle", ufp_rdata, 32'h0);
      if (dfp_resp) dfp_resp = 0;
      else if (late_pulse) begin
         dfp_resp = 1; dfp_rdata = '1; late_pulse = 0;
      end else if (resp_en && dfp_read) begin
         if (wcnt == 0) held_addr = dfp_addr;
         else chk("dfp_addr_stable", dfp_addr, held_addr);
         wcnt++;
         if (wcnt >= lat) begin
            dfp_resp = 1; dfp_rdata = mk_line(dfp_addr);
            got_q.push_back(dfp_addr); last_fill_cyc = cyc; wcnt = 0;
         end
      end
      if (!resp_en) wcnt = 0;
   end

   always @(negedge clk) begin
      if (n_dfp_resp) n_dfp_resp = 0;
      else if (n_dfp_read) begin
         n_dfp_resp = 1; n_dfp_rdata = mk_line(n_dfp_addr); n_reads++;
      end
   end

   // Reference model: set of resident lines, buffer line, and pending arm target.
   bit          res[int unsigned];
   bit          pb_v = 0, armed = 0, awrap = 0;
   int unsigned pb_l = 0, atgt = 0;

   task automatic m_clear();
      res.delete(); pb_v = 0; armed = 0; exp_q.delete(); got_q.delete();
   endtask

   task automatic m_arm(input int unsigned line);
      armed = 1; awrap = (line == MAXL); atgt = line + 1;
   endtask

   task automatic m_settle();
      if (armed) begin
         armed = 0;
         if (!awrap && !res.exists(atgt)) begin
            exp_q.push_back(atgt << LB); pb_v = 1; pb_l = atgt;
         end
      end
   endtask

   task automatic cmp_q();
      chk("dfp_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) chk("dfp_seq", got_q[i], exp_q[i]);
      got_q.delete(); exp_q.delete();
   endtask

   task automatic do_read(input logic [31:0] a);
      int unsigned line;
      int kind, t0, n;
      line = a >> LB;
      if (res.exists(line)) kind = 0;
      else if (pb_v && pb_l == line) begin kind = 1; res[line] = 1; pb_v = 0; m_arm(line); end
      else begin kind = 2; exp_q.push_back(a & 32'hFFFF_FFE0); res[line] = 1; m_arm(line); end
      @(negedge clk);
      ufp_addr = a; ufp_rmask = 4'hF; t0 = cyc; n = 0;
      do begin @(negedge clk); n++; end while (!ufp_resp && n < 200);
      chk("ufp_resp", {31'b0, ufp_resp}, 32'h1);
      chk("ufp_rdata", ufp_rdata, mem_word(a));
      if (kind == 2) chk("miss_lat", 32'(cyc), 32'(last_fill_cyc + 1));
      else           chk("hit_lat", 32'(cyc), 32'(t0 + 1));
      ufp_rmask = 0;
      repeat (25) @(negedge clk);
      m_settle();
      cmp_q();
   endtask

   task automatic do_inv(input logic [31:0] a);
      int unsigned line;
      int t0, n;
      line = a >> LB;
      res.delete(line);
      if (pb_v && pb_l == line) pb_v = 0;
      @(negedge clk);
      inv_req = 1; inv_addr = a; t0 = cyc; n = 0;
      do begin @(negedge clk); n++; end while (!inv_resp && n < 50);
      chk("inv_resp", {31'b0, inv_resp}, 32'h1);
      chk("inv_lat", 32'(cyc), 32'(t0 + 1));
      inv_req = 0;
      repeat (5) @(negedge clk);
      cmp_q();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; ufp_rmask = 0; inv_req = 0; n_ufp_rmask = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      m_clear();
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_ufp_resp"}, {31'b0, ufp_resp}, 32'h0);
      chk({tag, "_ufp_rdata"}, ufp_rdata, 32'h0);
      chk({tag, "_dfp_read"}, {31'b0, dfp_read}, 32'h0);
      chk({tag, "_dfp_addr"}, dfp_addr, 32'h0);
      chk({tag, "_inv_resp"}, {31'b0, inv_resp}, 32'h0);
   endtask

   task automatic nd_read(input logic [31:0] a, input int exp_reads);
      int n;
      @(negedge clk);
      n_ufp_addr = a; n_ufp_rmask = 4'hF; n = 0;
      do begin @(negedge clk); n++; end while (!n_ufp_resp && n < 100);
      chk("nopf_rdata", n_ufp_rdata, mem_word(a));
      n_ufp_rmask = 0;
      chk("nopf_reads", 32'(n_reads), 32'(exp_reads));
      repeat (20) @(negedge clk);
      chk("nopf_no_pf", 32'(n_reads), 32'(exp_reads));
   endtask

   initial begin
      int n;
      logic [31:0] a;
      repeat (2) @(negedge clk);
      chk_outs_zero("reset");
      rst = 0;

      // Cold miss, buffer hit, invalidation of cached and buffered lines, wrap.
      lat = 3;
      do_read(32'h0000_1004);
      do_read(32'h0000_1024);
      do_inv(32'h0000_1000);
      do_read(32'h0000_1004);
      do_inv(32'h0000_1040);
      do_read(32'h0000_1044);
      do_read(32'hFFFF_FFE0);

      // Reset two cycles into a fill; a late dfp_resp must be ignored.
      resp_en = 0;
      @(negedge clk);
      ufp_addr = 32'h0000_3008; ufp_rmask = 4'hF; n = 0;
      do begin @(negedge clk); n++; end while (!dfp_read && n < 20);
      chk("rstfill_read", {31'b0, dfp_read}, 32'h1);
      chk("rstfill_addr", dfp_addr, 32'h0000_3000);
      @(negedge clk);
      rst = 1; ufp_rmask = 0;
      @(negedge clk);
      chk_outs_zero("rstfill");
      rst = 0; late_pulse = 1;
      repeat (4) begin
         @(negedge clk);
         chk("late_dfp_read", {31'b0, dfp_read}, 32'h0);
         chk("late_ufp_resp", {31'b0, ufp_resp}, 32'h0);
      end
      resp_en = 1;
      m_clear();
      do_read(32'h0000_3008);

      // Tree-PLRU: A,B,C,D fill ways 0-3, A re-touched, E must evict C (way 2).
      do_reset();
      lat = 2;
      do_read(32'h0000_0200); do_read(32'h0000_0400);
      do_read(32'h0000_0600); do_read(32'h0000_0800);
      do_read(32'h0000_0204);
      do_read(32'h0000_0A00);
      res.delete(32'h0000_0600 >> LB);
      do_read(32'h0000_0A04); do_read(32'h0000_0208);
      do_read(32'h0000_0408); do_read(32'h0000_0808);
      do_read(32'h0000_060C);

      // Random reads/invalidates over 32 lines (two tags per set, no eviction).
      do_reset();
      for (int i = 0; i < 40; i++) begin
         lat = $urandom_range(1, 4);
         a = 32'h0004_0000 + 32'($urandom_range(0, 31)) * 32 + 32'($urandom_range(0, 7)) * 4;
         if ($urandom_range(0, 3) == 0) do_inv(a);
         else do_read(a);
      end

      // Prefetch disabled: only demand misses reach memory.
      n_reads = 0;
      nd_read(32'h0000_5004, 1);
      nd_read(32'h0000_5024, 2);
      nd_read(32'h0000_5008, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
